// File: rtl/serial_collect_if.sv
// ============================================================================
// serial_collect_if : serial-in / parallel-out handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_collect_if #(
  parameter int N  = 4,
  parameter int CW = 3
);
  logic          clr;
  logic          dir;
  logic          sin;
  logic          sin_valid;
  logic [N-1:0]  word;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic [CW-1:0] count;
  logic          overrun;

  // Source / consumer side: feeds the bit stream and accepts words.
  modport master (
    output clr, dir, sin, sin_valid, word_ready,
    input  word, word_valid, busy, count, overrun
  );

  // Collector side.
  modport slave (
    input  clr, dir, sin, sin_valid, word_ready,
    output word, word_valid, busy, count, overrun
  );
endinterface

`default_nettype wire

// File: rtl/serial_collect.sv
// ============================================================================
// serial_collect : assembles qualified serial bits into N-bit words (LSB- or
// MSB-first) and presents them on a registered valid/ready output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_collect #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  wire              clk,
  input  wire              rst,
  serial_collect_if.slave  bus
);

  localparam logic [CW-1:0] c_last = CW'(N - 1);

  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] count_q, count_d;
  logic          ord_q, ord_d;
  logic [N-1:0]  word_q, word_d;
  logic          word_valid_q, word_valid_d;
  logic          overrun_q, overrun_d;

  logic          w_accept;
  logic          w_first;
  logic          w_order;
  logic          w_complete;
  logic          w_consume;
  logic [N-1:0]  w_shifted;

  always_comb begin
    w_accept   = bus.sin_valid & ~bus.clr;
    w_first    = (count_q == '0);
    // Order is taken live from dir on the first bit, then from the latch.
    w_order    = w_first ? bus.dir : ord_q;
    w_shifted  = w_order ? {bus.sin, sreg_q[N-1:1]} : {sreg_q[N-2:0], bus.sin};
    w_complete = w_accept & (count_q == c_last);
    w_consume  = word_valid_q & bus.word_ready;
  end

  always_comb begin
    sreg_d       = sreg_q;
    count_d      = count_q;
    ord_d        = ord_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    if (bus.clr) begin
      sreg_d       = '0;
      count_d      = '0;
      word_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (w_consume) begin
        word_valid_d = 1'b0;
      end
      if (w_accept) begin
        ord_d  = w_order;
        sreg_d = w_shifted;
        if (w_complete) begin
          word_d       = w_shifted;
          word_valid_d = 1'b1;
          count_d      = '0;
          if (word_valid_q && !bus.word_ready) begin
            overrun_d = 1'b1;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q       <= '0;
      count_q      <= '0;
      ord_q        <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      count_q      <= count_d;
      ord_q        <= ord_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.count      = count_q;
  assign bus.busy       = (count_q != '0);
  assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_collect.sv
// ============================================================================
// tb_serial_collect : directed + randomized bench for serial_collect with a
// bit-list reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_collect;

  localparam int N  = 4;
  localparam int CW = 3;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  serial_collect_if #(.N(N), .CW(CW)) bus ();

  serial_collect #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: keeps the bits of the current word as a list and builds
  // the word arithmetically once N have arrived.
  logic [N-1:0] m_word;
  bit           m_valid;
  bit           m_ovr;
  int           m_cnt;
  bit           m_ord;
  bit           m_bits [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word  = '0;
      m_valid = 0;
      m_ovr   = 0;
      m_cnt   = 0;
      m_ord   = 0;
    end else if (bus.clr) begin
      m_cnt   = 0;
      m_valid = 0;
      m_ovr   = 0;
    end else begin
      bit consumed;
      bit done;
      logic [N-1:0] w;
      consumed = m_valid && bus.word_ready;
      done     = 0;
      if (bus.sin_valid) begin
        if (m_cnt == 0) m_ord = bus.dir;
        m_bits[m_cnt] = bus.sin;
        m_cnt++;
        if (m_cnt == N) begin
          w = '0;
          for (int i = 0; i < N; i++) begin
            if (m_ord) w[i] = m_bits[i];
            else       w[N-1-i] = m_bits[i];
          end
          if (m_valid && !consumed) m_ovr = 1;
          m_word  = w;
          m_valid = 1;
          m_cnt   = 0;
          done    = 1;
        end
      end
      if (!done && consumed) m_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_count", 32'(bus.count), 32'(m_cnt));
      chk("cmp_busy", 32'(bus.busy), 32'(m_cnt != 0));
      chk("cmp_valid", 32'(bus.word_valid), 32'(m_valid));
      chk("cmp_overrun", 32'(bus.overrun), 32'(m_ovr));
      if (m_valid) chk("cmp_word", 32'(bus.word), 32'(m_word));
    end
  end

  task automatic step(input logic s, input logic v, input logic d, input logic r, input logic c);
    bus.sin        = s;
    bus.sin_valid  = v;
    bus.dir        = d;
    bus.word_ready = r;
    bus.clr        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [3:0] pat;
    rst = 1'b1;
    bus.sin = 0; bus.sin_valid = 0; bus.dir = 0; bus.word_ready = 0; bus.clr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_word", 32'(bus.word), 0);
    chk("rst_valid", 32'(bus.word_valid), 0);
    chk("rst_count", 32'(bus.count), 0);

    // 1: asynchronous reset mid-word
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("t1_count_pre", 32'(bus.count), 2);
    rst = 1'b1;
    #1;
    chk("t1_count", 32'(bus.count), 0);
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_valid", 32'(bus.word_valid), 0);
    chk("t1_overrun", 32'(bus.overrun), 0);
    chk("t1_word", 32'(bus.word), 0);
    rst = 1'b0;

    // 2: LSB-first 1,0,1,1 -> D
    step(1, 1, 1, 0, 0); chk("t2_count1", 32'(bus.count), 1);
    step(0, 1, 1, 0, 0); chk("t2_count2", 32'(bus.count), 2);
    step(1, 1, 1, 0, 0); chk("t2_count3", 32'(bus.count), 3);
    chk("t2_valid_early", 32'(bus.word_valid), 0);
    step(1, 1, 1, 0, 0); chk("t2_count0", 32'(bus.count), 0);
    chk("t2_valid", 32'(bus.word_valid), 1);
    chk("t2_word", 32'(bus.word), 32'hD);
    chk("t2_model", 32'(m_word), 32'hD);
    idle(1);
    chk("t2_consumed", 32'(bus.word_valid), 0);

    // 3: MSB-first with gaps, dir toggled after first bit -> B
    step(1, 1, 0, 0, 0); idle(0);
    step(0, 1, 1, 0, 0); idle(0); idle(0);
    step(1, 1, 1, 0, 0); idle(0);
    step(1, 1, 1, 0, 0);
    chk("t3_word", 32'(bus.word), 32'hB);
    chk("t3_model", 32'(m_word), 32'hB);
    chk("t3_valid", 32'(bus.word_valid), 1);
    idle(1);

    // 4: overrun, D then 3 LSB-first with no consumer
    step(1, 1, 1, 0, 0); step(0, 1, 1, 0, 0); step(1, 1, 1, 0, 0); step(1, 1, 1, 0, 0);
    chk("t4_ovr_first", 32'(bus.overrun), 0);
    step(1, 1, 1, 0, 0); step(1, 1, 1, 0, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0);
    chk("t4_word", 32'(bus.word), 32'h3);
    chk("t4_valid", 32'(bus.word_valid), 1);
    chk("t4_overrun", 32'(bus.overrun), 1);
    idle(1);
    chk("t4_valid_after", 32'(bus.word_valid), 0);
    chk("t4_ovr_sticky", 32'(bus.overrun), 1);
    step(0, 0, 0, 0, 1);
    chk("t4_ovr_clr", 32'(bus.overrun), 0);

    // 5: back-to-back A then 5, consumed on the cycle word 2 completes
    step(0, 1, 1, 0, 0); step(1, 1, 1, 0, 0); step(0, 1, 1, 0, 0); step(1, 1, 1, 0, 0);
    chk("t5_word1", 32'(bus.word), 32'hA);
    step(1, 1, 1, 0, 0); chk("t5_hold", 32'(bus.word), 32'hA);
    step(0, 1, 1, 0, 0); step(1, 1, 1, 0, 0);
    chk("t5_valid_mid", 32'(bus.word_valid), 1);
    step(0, 1, 1, 1, 0);
    chk("t5_word2", 32'(bus.word), 32'h5);
    chk("t5_valid", 32'(bus.word_valid), 1);
    chk("t5_overrun", 32'(bus.overrun), 0);

    // 6: flush after 3 bits while a word is pending
    step(1, 1, 1, 0, 0); step(1, 1, 1, 0, 0); step(1, 1, 1, 0, 0);
    chk("t6_count_pre", 32'(bus.count), 3);
    step(1, 1, 1, 0, 1);
    chk("t6_count", 32'(bus.count), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_valid", 32'(bus.word_valid), 0);
    chk("t6_overrun", 32'(bus.overrun), 0);
    step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    chk("t6_word", 32'(bus.word), 32'h6);
    chk("t6_valid_new", 32'(bus.word_valid), 1);
    idle(1);

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      pat = 4'($urandom);
      step(pat[0], ($urandom_range(9) < 7), pat[1], pat[2],
           ($urandom_range(49) == 0));
      if ($urandom_range(299) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
